// File: rtl/cuenta1_cableada.sv
// Ones-counter coprocessor: 3-bit shift register datapath plus a hardwired,
// state-decoded control unit with a start/fin handshake.
module cuenta1_cableada (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] valor,
    input  logic       start,
    output logic [3:0] cuenta,
    output logic       fin
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        LOOP = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t     r_state;
    state_t     w_next_state;

    logic [2:0] r_a;
    logic [3:0] r_c;
    logic       r_fin;

    logic       w_z;
    logic       w_a0;

    logic       w_ld_a;
    logic       w_clr_c;
    logic       w_inc_c;
    logic       w_shr_a;
    logic       w_done;

    assign w_z  = (r_a == 3'b000);
    assign w_a0 = r_a[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Control word is a pure decode of the current state and datapath status.
    always_comb begin
        w_next_state = IDLE;
        w_ld_a       = 1'b0;
        w_clr_c      = 1'b0;
        w_inc_c      = 1'b0;
        w_shr_a      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                w_next_state = start ? LOAD : IDLE;
            end
            LOAD: begin
                w_ld_a       = 1'b1;
                w_clr_c      = 1'b1;
                w_next_state = LOOP;
            end
            LOOP: begin
                if (w_z) begin
                    w_next_state = DONE;
                end else begin
                    w_shr_a      = 1'b1;
                    w_inc_c      = w_a0;
                    w_next_state = LOOP;
                end
            end
            DONE: begin
                w_done       = 1'b1;
                w_next_state = start ? LOAD : DONE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a <= 3'b000;
        end else if (w_ld_a) begin
            r_a <= valor;
        end else if (w_shr_a) begin
            r_a <= r_a >> 1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_c <= 4'd0;
        end else if (w_clr_c) begin
            r_c <= 4'd0;
        end else if (w_inc_c) begin
            r_c <= r_c + 4'd1;
        end
    end

    // fin is registered from the state being entered, so it is high exactly while in DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fin <= 1'b0;
        end else begin
            r_fin <= (w_next_state == DONE);
        end
    end

    assign cuenta = r_c;
    assign fin    = r_fin;

    logic w_unused;
    assign w_unused = w_done;

endmodule

// File: tb/tb_cuenta1_cableada.sv
// Directed self-checking bench for cuenta1_cableada.
module tb_cuenta1_cableada;

    logic       clk;
    logic       reset_n;
    logic [2:0] valor;
    logic       start;
    logic [3:0] cuenta;
    logic       fin;

    int testsRun    = 0;
    int testsFailed = 0;

    cuenta1_cableada dut (
        .clk     (clk),
        .reset_n (reset_n),
        .valor   (valor),
        .start   (start),
        .cuenta  (cuenta),
        .fin     (fin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives a one-cycle start pulse; returns 1ns after E0.
    task automatic pulseStart(input logic [2:0] v);
        valor = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b1;
        valor   = 3'b111;
        #2;
        testsRun++;
        if (cuenta !== 4'd0 || fin !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_initial: cuenta=%0d fin=%b required cuenta=0 fin=0", cuenta, fin);
        end
        repeat (3) @(posedge clk);
        #1;
        testsRun++;
        if (cuenta !== 4'd0 || fin !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_held: cuenta=%0d fin=%b required cuenta=0 fin=0", cuenta, fin);
        end
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        testsRun++;
        if (cuenta !== 4'd0 || fin !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL idle_no_start: cuenta=%0d fin=%b required cuenta=0 fin=0", cuenta, fin);
        end
    endtask

    task automatic test_count_111();
        pulseStart(3'b111);
        repeat (4) @(posedge clk);
        #1;
        testsRun++;
        if (fin !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL c111_early_fin: fin=%b required 0 after E4", fin);
        end
        @(posedge clk);
        #1;
        testsRun++;
        if (fin !== 1'b1 || cuenta !== 4'd3) begin
            testsFailed++;
            $display("[TB] FAIL c111_done: cuenta=%0d fin=%b required cuenta=3 fin=1", cuenta, fin);
        end
        repeat (3) @(posedge clk);
        #1;
        testsRun++;
        if (fin !== 1'b1 || cuenta !== 4'd3) begin
            testsFailed++;
            $display("[TB] FAIL c111_hold: cuenta=%0d fin=%b required cuenta=3 fin=1", cuenta, fin);
        end
    endtask

    task automatic test_patterns();
        logic [2:0] vals [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
        int         lats [8] = '{2, 3, 4, 4, 5, 5, 5, 5};
        logic [3:0] cnts [8] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd1, 4'd2, 4'd2, 4'd3};
        for (int i = 0; i < 8; i++) begin
            pulseStart(vals[i]);
            repeat (lats[i] - 1) @(posedge clk);
            #1;
            testsRun++;
            if (fin !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL pattern_early_fin valor=%b: fin=%b required 0 after E%0d", vals[i], fin, lats[i] - 1);
            end
            @(posedge clk);
            #1;
            testsRun++;
            if (fin !== 1'b1 || cuenta !== cnts[i]) begin
                testsFailed++;
                $display("[TB] FAIL pattern_done valor=%b: cuenta=%0d fin=%b required cuenta=%0d fin=1", vals[i], cuenta, fin, cnts[i]);
            end
        end
    endtask

    task automatic test_valor_change();
        pulseStart(3'b110);
        @(posedge clk);
        #1;
        valor = 3'b001;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        valor = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        testsRun++;
        if (fin !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL vchange_early_fin: fin=%b required 0 after E4", fin);
        end
        @(posedge clk);
        #1;
        testsRun++;
        if (fin !== 1'b1 || cuenta !== 4'd2) begin
            testsFailed++;
            $display("[TB] FAIL vchange_done: cuenta=%0d fin=%b required cuenta=2 fin=1", cuenta, fin);
        end
    endtask

    task automatic test_async_reset();
        pulseStart(3'b111);
        repeat (3) @(posedge clk);
        #1;
        testsRun++;
        if (cuenta !== 4'd2 || fin !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midloop_count: cuenta=%0d fin=%b required cuenta=2 fin=0", cuenta, fin);
        end
        #2;
        reset_n = 1'b0;
        #1;
        testsRun++;
        if (cuenta !== 4'd0 || fin !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL async_reset: cuenta=%0d fin=%b required cuenta=0 fin=0", cuenta, fin);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        testsRun++;
        if (cuenta !== 4'd0 || fin !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL post_reset_idle: cuenta=%0d fin=%b required cuenta=0 fin=0", cuenta, fin);
        end
        pulseStart(3'b011);
        repeat (3) @(posedge clk);
        #1;
        testsRun++;
        if (fin !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL post_reset_early_fin: fin=%b required 0 after E3", fin);
        end
        @(posedge clk);
        #1;
        testsRun++;
        if (fin !== 1'b1 || cuenta !== 4'd2) begin
            testsFailed++;
            $display("[TB] FAIL post_reset_done: cuenta=%0d fin=%b required cuenta=2 fin=1", cuenta, fin);
        end
    endtask

    task automatic test_restart();
        pulseStart(3'b111);
        repeat (5) @(posedge clk);
        #1;
        testsRun++;
        if (fin !== 1'b1 || cuenta !== 4'd3) begin
            testsFailed++;
            $display("[TB] FAIL restart_setup: cuenta=%0d fin=%b required cuenta=3 fin=1", cuenta, fin);
        end
        pulseStart(3'b010);
        testsRun++;
        if (fin !== 1'b0 || cuenta !== 4'd3) begin
            testsFailed++;
            $display("[TB] FAIL restart_e0: cuenta=%0d fin=%b required cuenta=3 fin=0", cuenta, fin);
        end
        @(posedge clk);
        #1;
        testsRun++;
        if (cuenta !== 4'd0) begin
            testsFailed++;
            $display("[TB] FAIL restart_clear: cuenta=%0d required 0 after E1", cuenta);
        end
        repeat (3) @(posedge clk);
        #1;
        testsRun++;
        if (fin !== 1'b1 || cuenta !== 4'd1) begin
            testsFailed++;
            $display("[TB] FAIL restart_done: cuenta=%0d fin=%b required cuenta=1 fin=1", cuenta, fin);
        end
    endtask

    task automatic test_back_to_back();
        logic expFin [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        valor = 3'b001;
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            testsRun++;
            if (fin !== expFin[i] || (expFin[i] && cuenta !== 4'd1)) begin
                testsFailed++;
                $display("[TB] FAIL held_start E%0d: fin=%b cuenta=%0d required fin=%b cuenta=1 when done", i, fin, cuenta, expFin[i]);
            end
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        testsRun++;
        if (fin !== 1'b1 || cuenta !== 4'd1) begin
            testsFailed++;
            $display("[TB] FAIL held_start_release: cuenta=%0d fin=%b required cuenta=1 fin=1", cuenta, fin);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        valor   = 3'b000;
        test_reset();
        test_count_111();
        test_patterns();
        test_valor_change();
        test_async_reset();
        test_restart();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
